multi_digit_display: RTL and testbench

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/multi_digit_display.sv | 112 +++++++++++
 tb/tb_multi_digit_display.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multi_digit_display.sv
// Time-multiplexed BCD display driver: scans DIGITS digits, decodes each one to a
// 15-segment code, and applies leading-zero blanking and per-digit blinking.
module multi_digit_display #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [14:0]           segment_pattern,
  output logic [DIGITS-1:0]     digit_enable
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [4*DIGITS-1:0] held_q, held_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                phase_q, phase_d;   // 1 = hidden half of the blink cycle
  logic [14:0]         seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;

  logic                scan_wrap, idx_wrap, frame_wrap;
  logic [3:0]          sel_digit;
  logic                sel_lz, sel_blink, lz_run;

  function automatic logic [14:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 15'h0C3F;
      4'd1:    decode = 15'h0406;
      4'd2:    decode = 15'h00DB;
      4'd3:    decode = 15'h00CF;
      4'd4:    decode = 15'h00E6;
      4'd5:    decode = 15'h00ED;
      4'd6:    decode = 15'h00FD;
      4'd7:    decode = 15'h1401;
      4'd8:    decode = 15'h00FF;
      4'd9:    decode = 15'h00EF;
      default: decode = 15'h0000;
    endcase
  endfunction

  always_comb begin
    scan_wrap  = (scan_q == SW'(SCAN_DIV - 1));
    idx_wrap   = (idx_q == IW'(DIGITS - 1));
    frame_wrap = (frame_q == FW'(BLINK_FRAMES - 1));

    held_d  = load ? digits_in : held_q;
    scan_d  = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (scan_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + 1'b1;
      if (idx_wrap) begin
        frame_d = frame_wrap ? '0 : frame_q + 1'b1;
        if (frame_wrap) phase_d = ~phase_q;
      end
    end

    // Walk from the most significant digit down; lz_run stays set while every
    // digit seen so far is zero, which is exactly the leading-zero condition.
    sel_digit = 4'd0;
    sel_lz    = 1'b0;
    sel_blink = 1'b0;
    lz_run    = 1'b1;
    en_d      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (held_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        sel_digit = held_q[4*i +: 4];
        sel_lz    = lz_run && (i != 0);
        sel_blink = blink_en[i];
        en_d[i]   = 1'b1;
      end
    end

    seg_d = decode(sel_digit);
    if ((blank_lz && sel_lz) || (phase_q && sel_blink)) seg_d = 15'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q  <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      seg_q   <= '0;
      en_q    <= '0;
    end else begin
      held_q  <= held_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign segment_pattern = seg_q;
  assign digit_enable    = en_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed bench for multi_digit_display (4 digits, scan 4, blink 2) with a
// closed-form timing model feeding an expected-value queue.
module tb_multi_digit_display;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  typedef struct packed {
    logic [14:0] seg;
    logic [3:0]  en;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic [14:0] segment_pattern;
  logic [3:0]  digit_enable;

  exp_t        sb_q[$];
  logic [15:0] m_held;
  int          m_n;
  int          checks = 0;
  int          errors = 0;
  logic [14:0] tbl [16];

  multi_digit_display #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk             (clk),
    .reset           (reset),
    .digits_in       (digits_in),
    .load            (load),
    .blank_lz        (blank_lz),
    .blink_en        (blink_en),
    .segment_pattern (segment_pattern),
    .digit_enable    (digit_enable)
  );

  always #5 clk = ~clk;

  // n = number of non-reset edges already taken; the output appearing on the
  // next edge reflects the scan state after those n edges.
  function automatic exp_t model(input logic [15:0] held, input int n,
                                 input logic blank, input logic [3:0] blink);
    exp_t        e;
    int          idx;
    int          frame;
    logic        hidden;
    logic [15:0] upper;
    logic        lz;
    idx    = (n / SD) % D;
    frame  = n / (SD * D);
    hidden = ((frame / BF) % 2) == 1;
    upper  = held >> (4 * idx);
    lz     = (idx >= 1) && (upper == 16'h0000);
    e.en   = 4'b0001 << idx;
    if ((blank && lz) || (hidden && blink[idx])) e.seg = 15'h0000;
    else e.seg = tbl[upper[3:0]];
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic ld, input logic [15:0] d,
                     input string tag);
    exp_t e;
    reset     = rst;
    load      = ld;
    digits_in = d;
    if (rst) e = '0;
    else e = model(m_held, m_n, blank_lz, blink_en);
    sb_q.push_back(e);
    if (rst) begin
      m_held = 16'h0000;
      m_n    = 0;
    end else begin
      if (ld) m_held = d;
      m_n++;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (segment_pattern === e.seg) else begin
      errors++;
      $error("FAIL %s seg: got %h expected %h (n=%0d)", tag, segment_pattern, e.seg, m_n);
    end
    checks++;
    assert (digit_enable === e.en) else begin
      errors++;
      $error("FAIL %s en: got %b expected %b (n=%0d)", tag, digit_enable, e.en, m_n);
    end
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, 16'h0000, tag);
  endtask

  initial begin
    tbl = '{15'h0C3F, 15'h0406, 15'h00DB, 15'h00CF, 15'h00E6, 15'h00ED,
            15'h00FD, 15'h1401, 15'h00FF, 15'h00EF, 15'h0000, 15'h0000,
            15'h0000, 15'h0000, 15'h0000, 15'h0000};
    m_held    = 16'h0000;
    m_n       = 0;
    blank_lz  = 1'b0;
    blink_en  = 4'b0000;
    reset     = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;

    cyc(1'b1, 1'b0, 16'h0000, "reset0");
    cyc(1'b1, 1'b0, 16'h0000, "reset1");
    run(20, "scan_zero");

    cyc(1'b0, 1'b1, 16'h1279, "load_1279");
    run(16, "show_1279");

    blank_lz = 1'b1;
    cyc(1'b0, 1'b1, 16'h0005, "load_0005");
    run(16, "lz_0005");
    cyc(1'b0, 1'b1, 16'h0000, "load_0000");
    run(16, "lz_0000");

    blank_lz = 1'b0;
    cyc(1'b0, 1'b1, 16'h000A, "load_000A");
    run(16, "code_blank");

    // reset must win over a simultaneous load
    cyc(1'b1, 1'b1, 16'h0008, "rst_vs_load");
    blink_en = 4'b0001;
    cyc(1'b0, 1'b1, 16'h0008, "load_0008");
    while (m_n < 104) cyc(1'b0, 1'b0, 16'h0000, "blink");

    cyc(1'b1, 1'b0, 16'h0000, "rst_mid_blink");
    run(20, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
